// File: rtl/cordic_vector.sv
// cordic_vector: bit-serial vectoring-mode CORDIC; returns |(x0,y0)|*gain and atan2(y0,x0).
// Ports: clk, rst, start, x0, y0 -> mag, z, busy, done, err, i. Macro: CORDIC_VEC_GAIN_EN.
module cordic_vector #(
   parameter int WIDTH = 16,
   parameter int ITER  = 13
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] x0,
   input  logic signed [WIDTH-1:0] y0,
   output logic signed [WIDTH-1:0] mag,
   output logic signed [WIDTH-1:0] z,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [3:0]              i
);

   localparam int SW = $clog2(WIDTH + 1);
   localparam int LW = $clog2(WIDTH);

`ifdef CORDIC_VEC_GAIN_EN
   typedef enum logic [1:0] {IDLE, RUN, GAIN, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] xs, ys, zs;
   logic [WIDTH-1:0] xr, yr, zr;
   logic             cx, cy, cz;
   logic [SW-1:0]    s;
   logic [3:0]       k;
`ifdef CORDIC_VEC_GAIN_EN
   logic [1:0]       p;
   int               sh;
`endif

   logic             d;
   logic [WIDTH-1:0] rk;
   logic             xa, xb, xc, ya, yb, yc, za, zb, zc;
   logic [1:0]       sx, sy, sz;
   logic             last;

   function automatic logic [15:0] rom(input logic [3:0] n);
      unique case (n)
         4'd0:    return 16'h3244;
         4'd1:    return 16'h1DAC;
         4'd2:    return 16'h0FAE;
         4'd3:    return 16'h07F5;
         4'd4:    return 16'h03FF;
         4'd5:    return 16'h0200;
         4'd6:    return 16'h0100;
         4'd7:    return 16'h0080;
         4'd8:    return 16'h0040;
         4'd9:    return 16'h0020;
         4'd10:   return 16'h0010;
         4'd11:   return 16'h0008;
         4'd12:   return 16'h0004;
         4'd13:   return 16'h0002;
         4'd14:   return 16'h0001;
         default: return 16'h0000;
      endcase
   endfunction

   // Bit n of v, saturating at the MSB so right shifts sign-extend.
   function automatic logic tap(input logic [WIDTH-1:0] v, input int n);
      logic [LW-1:0] idx;
      idx = (n > WIDTH - 1) ? LW'(WIDTH - 1) : LW'(n);
      return v[idx];
   endfunction

   assign i    = k;
   assign last = (s == SW'(WIDTH));

   always_comb begin
      d  = ys[WIDTH-1];
      rk = WIDTH'(rom(k));
      // Subtraction = inverted operand plus carry-in 1 on the first bit.
      xa = tap(xs, int'(s));
      xb = tap(ys, int'(s) + int'(k)) ^ d;
      xc = (s == '0) ? d : cx;
`ifdef CORDIC_VEC_GAIN_EN
      sh = (p == 2'd0) ? 3 : (p == 2'd1) ? 6 : 9;
      if (state == GAIN) begin
         // Pass 0: x>>>1 + x>>>3; later passes: acc - x>>>sh (acc kept in ys).
         xa = (p == 2'd0) ? tap(xs, int'(s) + 1) : tap(ys, int'(s));
         xb = tap(xs, int'(s) + sh) ^ (p != 2'd0);
         xc = (s == '0) ? (p != 2'd0) : cx;
      end
`endif
      ya = tap(ys, int'(s));
      yb = tap(xs, int'(s) + int'(k)) ^ ~d;
      yc = (s == '0) ? ~d : cy;
      za = tap(zs, int'(s));
      zb = tap(rk, int'(s)) ^ d;
      zc = (s == '0) ? d : cz;
      sx = {1'b0, xa} + {1'b0, xb} + {1'b0, xc};
      sy = {1'b0, ya} + {1'b0, yb} + {1'b0, yc};
      sz = {1'b0, za} + {1'b0, zb} + {1'b0, zc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         xs    <= '0;
         ys    <= '0;
         zs    <= '0;
         xr    <= '0;
         yr    <= '0;
         zr    <= '0;
         cx    <= 1'b0;
         cy    <= 1'b0;
         cz    <= 1'b0;
         s     <= '0;
         k     <= '0;
`ifdef CORDIC_VEC_GAIN_EN
         p     <= '0;
`endif
         mag   <= '0;
         z     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  cx   <= 1'b0;
                  cy   <= 1'b0;
                  cz   <= 1'b0;
                  s    <= '0;
                  k    <= '0;
                  done <= 1'b0;
                  err  <= 1'b0;
                  if (x0[WIDTH-1]) begin
                     mag   <= '0;
                     z     <= '0;
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     xs    <= x0;
                     ys    <= y0;
                     zs    <= '0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (!last) begin
                  xr <= {sx[0], xr[WIDTH-1:1]};
                  yr <= {sy[0], yr[WIDTH-1:1]};
                  zr <= {sz[0], zr[WIDTH-1:1]};
                  cx <= sx[1];
                  cy <= sy[1];
                  cz <= sz[1];
                  s  <= s + 1'b1;
               end else begin
                  xs <= xr;
                  ys <= yr;
                  zs <= zr;
                  cx <= 1'b0;
                  cy <= 1'b0;
                  cz <= 1'b0;
                  s  <= '0;
                  if (k == 4'(ITER - 1)) begin
                     k <= '0;
`ifdef CORDIC_VEC_GAIN_EN
                     p     <= '0;
                     state <= GAIN;
`else
                     mag   <= xr;
                     z     <= zr;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
`endif
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
`ifdef CORDIC_VEC_GAIN_EN
            GAIN: begin
               if (!last) begin
                  yr <= {sx[0], yr[WIDTH-1:1]};
                  cx <= sx[1];
                  s  <= s + 1'b1;
               end else begin
                  ys <= yr;
                  cx <= 1'b0;
                  s  <= '0;
                  if (p == 2'd2) begin
                     mag   <= yr;
                     z     <= zs;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     p <= p + 1'b1;
                  end
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: table, random and corner-case checks of cordic_vector
// against a word-level CORDIC reference model.
module tb_cordic_vector;

   localparam int W = 16;
   localparam int N = 13;
`ifdef CORDIC_VEC_GAIN_EN
   localparam int LAT = (N + 3) * (W + 1);
`else
   localparam int LAT = N * (W + 1);
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic signed [W-1:0] x0 = '0;
   logic signed [W-1:0] y0 = '0;
   logic signed [W-1:0] mag, z;
   logic busy, done, err;
   logic [3:0] i;

   int nvec = 0;
   int nerr = 0;
   int rom_t [16] = '{'h3244, 'h1DAC, 'h0FAE, 'h07F5, 'h03FF, 'h0200,
                      'h0100, 'h0080, 'h0040, 'h0020, 'h0010, 'h0008,
                      'h0004, 'h0002, 'h0001, 'h0000};

   typedef struct {
      int x;
      int y;
      int ez;
      int em;
      int mt;
   } vec_t;

   cordic_vector #(.WIDTH(W), .ITER(N)) dut (
      .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
      .mag(mag), .z(z), .busy(busy), .done(done), .err(err), .i(i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic check_tol(input string nm, input int act, input int exp,
                            input int tol);
      nvec++;
      if (act > exp + tol || act < exp - tol) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d +/- %0d", nm, act, exp, tol);
      end
   endtask

   // Word-level vectoring CORDIC, 16-bit wraparound arithmetic.
   function automatic void model(input int xi, input int yi,
                                 output int m, output int zo);
      logic signed [W-1:0] x, y, zz, xn, yn;
      x  = 16'(xi);
      y  = 16'(yi);
      zz = '0;
      for (int k = 0; k < N; k++) begin
         if (y < 0) begin
            xn = x - (y >>> k);
            yn = y + (x >>> k);
            zz = zz - 16'(rom_t[k]);
         end else begin
            xn = x + (y >>> k);
            yn = y - (x >>> k);
            zz = zz + 16'(rom_t[k]);
         end
         x = xn;
         y = yn;
      end
`ifdef CORDIC_VEC_GAIN_EN
      x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
`endif
      m  = int'(x);
      zo = int'(zz);
   endfunction

   task automatic go(input int xv, input int yv);
      x0    = 16'(xv);
      y0    = 16'(yv);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat, output int bad);
      lat = lat0;
      bad = 0;
      while (!done && lat < LAT + 10) begin
         tick();
         lat++;
         if (!done) begin
            if (int'(i) != ((lat < N * (W + 1)) ? lat / (W + 1) : 0)) bad++;
            if (!busy) bad++;
         end
      end
   endtask

   task automatic finish_chk(input string nm, input int xv, input int yv,
                             input int lat, input int bad,
                             output int m, output int zz);
      int em, ez;
      model(xv, yv, em, ez);
      m  = int'(mag);
      zz = int'(z);
      check({nm, "_lat"}, lat, LAT);
      check({nm, "_iseq"}, bad, 0);
      check({nm, "_mag"}, m, em);
      check({nm, "_z"}, zz, ez);
      check({nm, "_flags"}, {busy, err}, 0);
   endtask

   task automatic run(input string nm, input int xv, input int yv,
                      output int m, output int zz);
      int lat, bad;
      go(xv, yv);
      wait_done(0, lat, bad);
      finish_chk(nm, xv, yv, lat, bad, m, zz);
   endtask

   initial begin
      vec_t tab [4];
      int m, zz, lat, bad, xv, yv;
`ifdef CORDIC_VEC_GAIN_EN
      tab[0] = '{10000, 0, 0, 10002, 16};
      tab[1] = '{10000, 10000, 12868, 14146, 16};
      tab[2] = '{0, 10000, 25736, 10002, 16};
      tab[3] = '{5000, -10000, -18139, 11183, 16};
`else
      tab[0] = '{10000, 0, 0, 16468, 8};
      tab[1] = '{10000, 10000, 12868, 23289, 12};
      tab[2] = '{0, 10000, 25736, 16468, 12};
      tab[3] = '{5000, -10000, -18139, 18411, 12};
`endif

      repeat (3) tick();
      check("rst_mag", int'(mag), 0);
      check("rst_z", int'(z), 0);
      check("rst_ctl", {busy, done, err, i}, 0);
      rst = 1'b0;
      repeat (2) tick();
      check("idle_ctl", {busy, done, err, i}, 0);

      foreach (tab[n]) begin
         run($sformatf("tab%0d", n), tab[n].x, tab[n].y, m, zz);
         check_tol($sformatf("tab%0d_ztol", n), zz, tab[n].ez, 4);
         check_tol($sformatf("tab%0d_mtol", n), m, tab[n].em, tab[n].mt);
      end

      for (int r = 0; r < 12; r++) begin
         xv = int'($urandom_range(13000));
         yv = int'($urandom_range(26000)) - 13000;
         run($sformatf("rnd%0d", r), xv, yv, m, zz);
      end

      go(-1, 0);
      check("err_done", {done, err, busy}, 3'b110);
      check("err_mag", int'(mag), 0);
      check("err_z", int'(z), 0);
      tick();
      check("err_hold", {done, err}, 2'b11);
      go(6000, 2000);
      check("err_clear", {done, err, busy}, 3'b001);
      wait_done(0, lat, bad);
      finish_chk("after_err", 6000, 2000, lat, bad, m, zz);

      go(8000, 3000);
      repeat (49) tick();
      x0    = 16'(1234);
      y0    = -16'sd500;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(50, lat, bad);
      finish_chk("busy_start", 8000, 3000, lat, bad, m, zz);

      go(7000, -7000);
      repeat (100) tick();
      rst = 1'b1;
      #1;
      check("midrst_mag", int'(mag), 0);
      check("midrst_z", int'(z), 0);
      check("midrst_ctl", {busy, done, err, i}, 0);
      tick();
      rst = 1'b0;
      run("post_rst", 9000, 4000, m, zz);

      rst   = 1'b1;
      start = 1'b1;
      x0    = 16'(5000);
      tick();
      start = 1'b0;
      rst   = 1'b0;
      tick();
      check("rst_start", {busy, done, err}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/cordic_vector.md
# cordic_vector

Bit-serial CORDIC engine in vectoring mode, the inverse of the rotation-mode `cordic` unit. It takes a Cartesian vector (x0, y0), drives y to zero by successive micro-rotations and returns the scaled magnitude and the angle atan2(y0, x0). It shares the rotation unit's number formats, its per-iteration bit-serial datapath (LSB-first add/sub with carry flop) and its start/done control style, so the two can be paired for coordinate conversion.

## Interface
- `WIDTH`, 16: datapath width (two's complement).
- `ITER`, 13: number of micro-rotations, 1..16.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request; samples `x0`/`y0`; ignored while `busy`=1.
- `x0` input signed WIDTH: input x; legal range 0..13000.
- `y0` input signed WIDTH: input y; legal range -13000..13000.
- `mag` output signed WIDTH: final x register (magnitude × 1.6468, or × ~1.0 with gain compensation).
- `z` output signed WIDTH: angle in radians × 2^14 (pi/4 = 12868).
- `busy` output 1: high from the cycle after an accepted `start` until `done` rises.
- `done` output 1: level; high while results are valid, cleared by the next accepted `start`.
- `err` output 1: set when `x0`<0 at start; held with `done`.
- `i` output 4: current iteration index (debug).

## Operation
- Angle ROM k=0..15, shared with the rotation unit: 0x3244, 0x1DAC, 0x0FAE, 0x07F5, 0x03FF, 0x0200, 0x0100, 0x0080, 0x0040, 0x0020, 0x0010, 0x0008, 0x0004, 0x0002, 0x0001, 0x0000.
- FSM states: IDLE, RUN, GAIN (only with the macro), DONE.
- IDLE/DONE + `start`:
  - If `x0`≥0: load x=x0, y=y0, z=0, k=0; go to RUN.
  - If `x0`<0: set `mag`=0, `z`=0, `err`=1; go to DONE directly.
- Iteration k (word-level equivalent; wraps mod 2^WIDTH):
  - d = y[WIDTH-1], sampled at the start of the iteration and held for all of its cycles.
  - d=0: x += y>>>k; y -= x>>>k; z += ROM[k].
  - d=1: x -= y>>>k; y += x>>>k; z -= ROM[k].
  - All right-hand values are taken from the iteration's start values.
- Serial realisation: three add/sub units, each with a 1-bit carry flop.
  - At step s, the shifted operand bit is `reg[min(s+k, WIDTH-1)]` of the iteration-start value, which gives sign extension.
  - Subtract is implemented as add of the inverted operand with carry-in 1.
  - Carries clear on the load cycle and on `start`.
- After iteration ITER-1: go to GAIN (macro defined) or DONE.
- DONE: `done`=1 and `busy`=0. Outputs hold until the next accepted `start`; `done` and `err` clear on that start edge.
- `rst`: FSM to IDLE; all registers, `mag`, `z`, `done`, `busy`, `err` and `i` go to 0. This applies mid-run as well; no partial result survives.

## Timing
- One iteration = WIDTH+1 cycles: WIDTH shift cycles (LSB first), then 1 load cycle that writes the results back and advances k.
- Latency from the `start` edge to `done`=1: ITER×(WIDTH+1) cycles (221 at defaults); +3×(WIDTH+1) (51 more) with the macro.
- Error path: `done`=1 one cycle after the `start` edge.
- `start` with `busy`=1: ignored, with no effect on state.
- `start` coincident with `rst`: `rst` wins.
- `i` = k during RUN; 0 otherwise.

## Configuration
- `CORDIC_VEC_GAIN_EN`:
  - Defined: adds the GAIN state, 3 serial passes of WIDTH+1 cycles each on x only.
  - The passes compute acc=(x>>>1); acc+=x>>>3; acc-=x>>>6; acc-=x>>>9, so `mag` ≈ 0.6074×x.
  - Undefined: no GAIN state; `mag` = raw x (gain 1.6468).

## Test plan
- Reset, then idle: all outputs 0; `start` with x0=10000, y0=0 -> `done` at +221 cycles; z within ±4 of 0; `mag` within ±8 of 16468 (10002 with macro, at +272).
- x0=10000, y0=10000 -> z 12868±4; `mag` 23289±12.
- x0=0, y0=10000 -> z 25736±4; x0=5000, y0=-10000 -> z -18139±4; `i` steps 0..12, each index held 17 cycles.
- x0=-1, y0=0 -> `err`=1, `done`=1 one cycle after start; `mag`=`z`=0; next legal start clears `err`.
- `start` pulsed at cycle 50 of a run -> ignored; result and latency unchanged.
- `rst` asserted at cycle 100 of a run -> all outputs 0 immediately; new start afterwards gives correct result at +221 cycles.
